// File: rtl/rst_req_sequencer_if.sv
// Request/reset handshake between the button long-press detector, the sequencer and its consumers.
interface rst_req_sequencer_if;
    logic rst_req_in;
    logic sys_rst_n;
    logic busy;
    logic rst_done;
    logic led_status;

    modport master (
        output rst_req_in,
        input  sys_rst_n,
        input  busy,
        input  rst_done,
        input  led_status
    );

    modport slave (
        input  rst_req_in,
        output sys_rst_n,
        output busy,
        output rst_done,
        output led_status
    );
endinterface

// File: rtl/rst_req_sequencer.sv
// Turns a long-press request level into one fixed-width active-low soft reset, then locks out.
// Define RST_SEQ_LED_BLINK_EN to blink led_status during the cooldown lockout.
module rst_req_sequencer #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned HOLD_MS     = 100,
    parameter int unsigned COOLDOWN_MS = 500,
    parameter int unsigned BLINK_MS    = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    rst_req_sequencer_if.slave bus
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MsMax = (HOLD_MS > COOLDOWN_MS) ? HOLD_MS : COOLDOWN_MS;
    localparam int unsigned MsW   = $clog2(MsMax + 1);

    if (TICK_DIV < 2 || HOLD_MS < 1 || COOLDOWN_MS < 1 || BLINK_MS < 1) begin : g_param_check
        $error("rst_req_sequencer: parameters out of range");
    end

    typedef enum logic [1:0] {StIdle, StAssert, StWaitRel, StCooldown} state_e;

    state_e state_q, state_d;

    logic req_meta_q, req_s_q, req_q;
    logic req_rise;

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [MsW-1:0]   ms_cnt_q, ms_cnt_d;
    logic             state_entry;

    logic sys_rst_n_q, sys_rst_n_d;
    logic busy_q, busy_d;
    logic rst_done_q, rst_done_d;
    logic led_q, led_d;

    // Request synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            req_meta_q <= bus.rst_req_in;
            req_s_q    <= req_meta_q;
            req_q      <= req_s_q;
        end
    end

    assign req_rise    = req_s_q & ~req_q;
    assign state_entry = (state_d != state_q);
    assign tick        = (tick_cnt_q == TickW'(TICK_DIV - 1));

    // Both timers restart on every state change so each state times from its own entry.
    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (state_entry || tick) begin
            tick_cnt_d = '0;
        end

        ms_cnt_d = ms_cnt_q;
        if (state_entry) begin
            ms_cnt_d = '0;
        end else if (tick && (ms_cnt_q != '1)) begin
            ms_cnt_d = ms_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            ms_cnt_q   <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Exits fire on the tick that brings the ms counter to its target.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_rise) begin
                    state_d = StAssert;
                end
            end
            StAssert: begin
                if (tick && (ms_cnt_q == MsW'(HOLD_MS - 1))) begin
                    state_d = StWaitRel;
                end
            end
            StWaitRel: begin
                if (!req_s_q) begin
                    state_d = StCooldown;
                end
            end
            StCooldown: begin
                if (req_s_q) begin
                    state_d = StWaitRel;
                end else if (tick && (ms_cnt_q == MsW'(COOLDOWN_MS - 1))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef RST_SEQ_LED_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_toggle;
    logic              cool_entry;

    assign cool_entry   = (state_d == StCooldown) && (state_q != StCooldown);
    assign blink_toggle = (state_q == StCooldown) && (state_d == StCooldown) && tick &&
                          (blink_cnt_q == BlinkW'(BLINK_MS - 1));

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (cool_entry) begin
            blink_cnt_d = '0;
        end else if ((state_q == StCooldown) && tick) begin
            blink_cnt_d = (blink_cnt_q == BlinkW'(BLINK_MS - 1)) ? '0 : blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end
`endif

    // Outputs are decoded from the next state and registered, so they align with state_q.
    always_comb begin
        sys_rst_n_d = (state_d != StAssert);
        busy_d      = (state_d != StIdle);
        rst_done_d  = (state_q == StAssert) && (state_d == StWaitRel);
`ifdef RST_SEQ_LED_BLINK_EN
        led_d = 1'b0;
        unique case (state_d)
            StIdle:     led_d = 1'b0;
            StAssert:   led_d = 1'b1;
            StWaitRel:  led_d = 1'b1;
            StCooldown: led_d = cool_entry ? 1'b1 : (blink_toggle ? ~led_q : led_q);
            default:    led_d = 1'b0;
        endcase
`else
        led_d = ~sys_rst_n_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            rst_done_q  <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            sys_rst_n_q <= sys_rst_n_d;
            busy_q      <= busy_d;
            rst_done_q  <= rst_done_d;
            led_q       <= led_d;
        end
    end

    assign bus.sys_rst_n  = sys_rst_n_q;
    assign bus.busy       = busy_q;
    assign bus.rst_done   = rst_done_q;
    assign bus.led_status = led_q;

endmodule

// File: tb/tb_rst_req_sequencer.sv
// Directed bench for rst_req_sequencer with short timing parameters (1 ms = 10 clk).
module tb_rst_req_sequencer;

    localparam int unsigned TickDiv = 10;
    localparam int unsigned HoldMs  = 3;
    localparam int unsigned CoolMs  = 5;
    localparam int unsigned BlinkMs = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rst_req_sequencer_if bus();

    rst_req_sequencer #(
        .TICK_DIV    (TickDiv),
        .HOLD_MS     (HoldMs),
        .COOLDOWN_MS (CoolMs),
        .BLINK_MS    (BlinkMs)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Edge monitor, sampled on the falling edge.
    int   n_pulses = 0, fall_cyc = 0, rise_cyc = 0;
    int   n_done = 0, done_cyc = 0;
    int   n_busy_fall = 0, busy_fall_cyc = 0, busy_hi = 0;
    int   led_err = 0;
    logic prev_sys = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (prev_sys && !bus.sys_rst_n) begin
            n_pulses <= n_pulses + 1;
            fall_cyc <= cyc;
        end
        if (!prev_sys && bus.sys_rst_n) rise_cyc <= cyc;
        if (bus.rst_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (prev_busy && !bus.busy) begin
            n_busy_fall   <= n_busy_fall + 1;
            busy_fall_cyc <= cyc;
        end
        if (bus.busy) busy_hi <= busy_hi + 1;
`ifndef RST_SEQ_LED_BLINK_EN
        if (bus.led_status !== !bus.sys_rst_n) led_err <= led_err + 1;
`endif
        prev_sys  <= bus.sys_rst_n;
        prev_busy <= bus.busy;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(bus.busy), 0);
        repeat (2) @(negedge clk);
    endtask

    int t, tr, p0, d0, bf0;

    initial begin
        bus.rst_req_in = 1'b0;
        rst_n          = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_sys_rst_n", int'(bus.sys_rst_n), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.rst_done), 0);
        check("rst_led", int'(bus.led_status), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_pulses", n_pulses, 0);
        check("idle_done", n_done, 0);
        check("idle_busy_hi", busy_hi, 0);

        // Single request: 50-cycle press.
        @(negedge clk);
        t = cyc; p0 = n_pulses; d0 = n_done;
        bus.rst_req_in = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (k == 50) bus.rst_req_in = 1'b0;
`ifdef RST_SEQ_LED_BLINK_EN
            // Cooldown spans k=53..102 and toggles at k=73 and k=93.
            if (k == 10)  check("blink_assert", int'(bus.led_status), 1);
            if (k == 40)  check("blink_waitrel", int'(bus.led_status), 1);
            if (k == 60)  check("blink_cool_a", int'(bus.led_status), 1);
            if (k == 80)  check("blink_cool_b", int'(bus.led_status), 0);
            if (k == 98)  check("blink_cool_c", int'(bus.led_status), 1);
            if (k == 105) check("blink_idle", int'(bus.led_status), 0);
`endif
        end
        wait_idle("single_idle", 50);
        check("single_pulses", n_pulses - p0, 1);
        check("single_latency", fall_cyc - t, 3);
        check("single_width", rise_cyc - fall_cyc, 30);
        check("single_done_cnt", n_done - d0, 1);
        check("single_done_at", done_cyc - t, 33);
        check("single_busy_fall", busy_fall_cyc - t, 103);

        // Long hold: one pulse only, parked in WAIT_REL until release.
        @(negedge clk);
        t = cyc; p0 = n_pulses; d0 = n_done;
        bus.rst_req_in = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 150) begin
                check("long_busy", int'(bus.busy), 1);
                check("long_sys_rst_n", int'(bus.sys_rst_n), 1);
            end
        end
        bus.rst_req_in = 1'b0;
        tr = cyc;
        wait_idle("long_idle", 100);
        check("long_pulses", n_pulses - p0, 1);
        check("long_width", rise_cyc - fall_cyc, 30);
        check("long_done_cnt", n_done - d0, 1);
        check("long_busy_fall", busy_fall_cyc - tr, 53);

        // Bounce 20 cycles into cooldown; cooldown restarts after final release at k=78.
        @(negedge clk);
        t = cyc; p0 = n_pulses; d0 = n_done; bf0 = n_busy_fall;
        bus.rst_req_in = 1'b1;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            if (k == 50) bus.rst_req_in = 1'b0;
            if (k == 73) bus.rst_req_in = 1'b1;
            if (k == 78) bus.rst_req_in = 1'b0;
        end
        wait_idle("bounce_idle", 50);
        check("bounce_pulses", n_pulses - p0, 1);
        check("bounce_done_cnt", n_done - d0, 1);
        check("bounce_busy_falls", n_busy_fall - bf0, 1);
        check("bounce_busy_fall", busy_fall_cyc - t, 131);

        // Async reset 10 cycles into the pulse.
        @(negedge clk);
        t = cyc; p0 = n_pulses; d0 = n_done;
        bus.rst_req_in = 1'b1;
        repeat (13) @(negedge clk);
        #2;
        rst_n          = 1'b0;
        bus.rst_req_in = 1'b0;
        #1;
        check("arst_sys_rst_n", int'(bus.sys_rst_n), 1);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.rst_done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_latency", fall_cyc - t, 3);
        check("arst_no_done", n_done - d0, 0);

        // Fresh request after the abort gets a full pulse.
        @(negedge clk);
        t = cyc; p0 = n_pulses; d0 = n_done;
        bus.rst_req_in = 1'b1;
        repeat (40) @(negedge clk);
        bus.rst_req_in = 1'b0;
        wait_idle("fresh_idle", 100);
        check("fresh_latency", fall_cyc - t, 3);
        check("fresh_width", rise_cyc - fall_cyc, 30);
        check("fresh_done_cnt", n_done - d0, 1);

`ifndef RST_SEQ_LED_BLINK_EN
        check("led_mirror_err", led_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
